// File: rtl/counter_arb_pkg.sv
// counter_arb_pkg: shared types and constants for the counter_arbiter block.
//   arb_state_t  - sequencer state encoding (IDLE, GRANT, RUN, DRAIN, DONE)
//   DIR_UP/DOWN  - job direction encoding as seen on req_dir / cnt_up_down
//   *_DEF        - default parameter values for the top level
package counter_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } arb_state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int NUM_REQ_DEF = 4;
  localparam int LEN_W_DEF   = 8;

endpackage

// File: rtl/counter_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker.
//   req  [N]     - request vector
//   ptr  [IDX_W] - index with highest priority this cycle
//   en           - when low, nothing is granted
//   gnt  [N]     - one-hot grant (all zero if nothing granted)
//   idx  [IDX_W] - encoded index of the grant
//   any          - a grant was issued
module rr_arbiter #(
  parameter int N = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int pos;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    if (en) begin
      // Scan from ptr upward, wrapping; the first requester found wins.
      for (int k = 0; k < N; k++) begin
        pos = (int'(ptr) + k) % N;
        if (!any && req[pos]) begin
          any      = 1'b1;
          gnt[pos] = 1'b1;
          idx      = IDX_W'(pos);
        end
      end
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// counter_arbiter: shares one 8-bit up/down counter among NUM_REQ requesters.
// Each accepted job drives the counter for exactly len cycles, then reports the
// final count and whether the counter overflowed during the job.
//   clk, rst_n       - clock, asynchronous active-low reset
//   req_valid/dir/len- per-requester job request (len packed LEN_W per requester)
//   req_ready        - one-hot accept strobe (only in GRANT)
//   done             - one-hot completion pulse to the job owner
//   done_count/ovf   - result, valid while done is high
//   busy             - high whenever not IDLE
//   cnt_enable/up_down - drive the shared counter
//   cnt_count/overflow - counter's registered outputs
module counter_arbiter
  import counter_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_dir,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       done,
  output logic [7:0]               done_count,
  output logic                     done_ovf,
  output logic                     busy,
  output logic                     cnt_enable,
  output logic                     cnt_up_down,
  input  logic [7:0]               cnt_count,
  input  logic                     cnt_overflow
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic             dir_q, dir_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       done_count_q, done_count_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [LEN_W-1:0]   gnt_len;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .en  (state_q == GRANT),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign gnt_len = req_len[gnt_idx*LEN_W +: LEN_W];

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    dir_d        = dir_q;
    remaining_d  = remaining_q;
    ovf_d        = ovf_q;
    done_count_d = done_count_q;
    rr_ptr_d     = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) state_d = GRANT;
      end
      GRANT: begin
        if (gnt_any) begin
          owner_d     = gnt_idx;
          dir_d       = req_dir[gnt_idx];
          remaining_d = gnt_len;
          ovf_d       = 1'b0;
          rr_ptr_d    = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d     = (gnt_len != '0) ? RUN : DRAIN;
        end else begin
          // Valid dropped before acceptance: nothing granted, pointer untouched.
          state_d = IDLE;
        end
      end
      RUN: begin
        ovf_d       = ovf_q | cnt_overflow;
        remaining_d = remaining_q - 1'b1;
        if (remaining_q == LEN_W'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        // Counter outputs now reflect the last step taken in RUN.
        ovf_d        = ovf_q | cnt_overflow;
        done_count_d = cnt_count;
        state_d      = DONE;
      end
      DONE: begin
        state_d = (|req_valid) ? GRANT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      dir_q        <= DIR_DOWN;
      remaining_q  <= '0;
      ovf_q        <= 1'b0;
      done_count_q <= 8'h00;
      rr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      dir_q        <= dir_d;
      remaining_q  <= remaining_d;
      ovf_q        <= ovf_d;
      done_count_q <= done_count_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign req_ready   = (state_q == GRANT) ? gnt : '0;
  assign done        = (state_q == DONE) ? (NUM_REQ'(1) << owner_q) : '0;
  assign done_count  = done_count_q;
  assign done_ovf    = (state_q == DONE) && ovf_q;
  assign busy        = (state_q != IDLE);
  assign cnt_enable  = (state_q == RUN);
  assign cnt_up_down = (state_q == RUN || state_q == DRAIN) ? dir_q : DIR_DOWN;

endmodule

// File: tb/tb_counter_arbiter.sv
module tb_counter_arbiter;

  localparam int N  = 4;
  localparam int LW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid, req_dir, req_ready, done;
  logic [N*LW-1:0] req_len;
  logic [7:0]      done_count, cnt_count;
  logic            done_ovf, busy, cnt_enable, cnt_up_down, cnt_overflow;

  always #5 clk = ~clk;

  counter_arbiter #(.NUM_REQ(N), .LEN_W(LW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_dir      (req_dir),
    .req_len      (req_len),
    .req_ready    (req_ready),
    .done         (done),
    .done_count   (done_count),
    .done_ovf     (done_ovf),
    .busy         (busy),
    .cnt_enable   (cnt_enable),
    .cnt_up_down  (cnt_up_down),
    .cnt_count    (cnt_count),
    .cnt_overflow (cnt_overflow)
  );

  // Stand-in for the shared 8-bit up/down counter, with a bench-only preset.
  logic       preset_req = 1'b0;
  logic [7:0] preset_val = 8'h00;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_count    <= 8'h00;
      cnt_overflow <= 1'b0;
    end else if (preset_req) begin
      cnt_count    <= preset_val;
      cnt_overflow <= 1'b0;
    end else if (cnt_enable) begin
      cnt_count    <= cnt_up_down ? cnt_count + 8'd1 : cnt_count - 8'd1;
      cnt_overflow <= cnt_up_down ? (cnt_count == 8'hFF) : (cnt_count == 8'h00);
    end else begin
      cnt_overflow <= 1'b0;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_ready"}, req_ready, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_done_count"}, done_count, 0);
    chk({p, "_done_ovf"}, done_ovf, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_cnt_enable"}, cnt_enable, 0);
    chk({p, "_cnt_up_down"}, cnt_up_down, 0);
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef enum {P_IDLE, P_GRANT, P_JOB} ph_t;
  ph_t        phase = P_IDLE;
  int         cyc = 0;
  int         m_ptr = 0;
  int         t_g, j_len, j_own, w;
  bit         j_dir, j_exp_ovf;
  logic [7:0] j_cnt, j_exp_count;
  logic [N-1:0] exp_ready;
  int         accept_cnt[N];
  int         done_seen[N];
  int         grant_log[$];
  int         grant_cyc_log[$];
  logic [7:0] last_count = 8'h00;
  logic       last_ovf = 1'b0;

  initial begin
    for (int i = 0; i < N; i++) begin
      accept_cnt[i] = 0;
      done_seen[i]  = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        chk_zero("in_reset");
        phase = P_IDLE;
        m_ptr = 0;
      end else begin
        case (phase)
          P_IDLE: begin
            chk("idle_busy", busy, 0);
            chk("idle_ready", req_ready, 0);
            chk("idle_en", cnt_enable, 0);
            chk("idle_done", done, 0);
            if (|req_valid) phase = P_GRANT;
          end
          P_GRANT: begin
            w = -1;
            for (int k = 0; k < N; k++) begin
              if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            exp_ready = '0;
            if (w >= 0) begin
              exp_ready   = N'(1) << w;
              j_own       = w;
              j_dir       = req_dir[w];
              j_len       = int'(req_len[w*LW +: LW]);
              j_cnt       = cnt_count;
              t_g         = cyc;
              j_exp_count = j_dir ? 8'(int'(j_cnt) + j_len) : 8'(int'(j_cnt) - j_len);
              j_exp_ovf   = j_dir ? (int'(j_cnt) + j_len > 255) : (j_len > int'(j_cnt));
              m_ptr       = (w + 1) % N;
              accept_cnt[w]++;
              grant_log.push_back(w);
              grant_cyc_log.push_back(cyc);
              phase = P_JOB;
            end else begin
              phase = P_IDLE;
            end
            chk("grant_ready", req_ready, exp_ready);
            chk("grant_busy", busy, 1);
            chk("grant_en", cnt_enable, 0);
            chk("grant_done", done, 0);
          end
          P_JOB: begin
            chk("job_busy", busy, 1);
            chk("job_ready", req_ready, 0);
            chk("job_en", cnt_enable, (cyc <= t_g + j_len) ? 1 : 0);
            if (cyc <= t_g + j_len + 1) chk("job_updown", cnt_up_down, j_dir);
            if (cyc == t_g + j_len + 2) begin
              chk("done_vec", done, N'(1) << j_own);
              chk("done_count", done_count, j_exp_count);
              chk("done_ovf", done_ovf, j_exp_ovf);
              last_count = done_count;
              last_ovf   = done_ovf;
              done_seen[j_own]++;
              phase = (|req_valid) ? P_GRANT : P_IDLE;
            end else begin
              chk("job_done_early", done, 0);
            end
          end
          default: phase = P_IDLE;
        endcase
      end
    end
  end

  // ---------------- requester driver ----------------
  typedef struct {
    bit dir;
    int len;
  } job_t;
  job_t jq[N][$];
  int   taken[N];

  task automatic apply();
    job_t j;
    for (int i = 0; i < N; i++) begin
      if (jq[i].size() > 0) begin
        j = jq[i][0];
        req_valid[i]        = 1'b1;
        req_dir[i]          = j.dir;
        req_len[i*LW +: LW] = LW'(j.len);
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (accept_cnt[i] != taken[i]) begin
        taken[i] = accept_cnt[i];
        if (jq[i].size() > 0) void'(jq[i].pop_front());
      end
    end
    apply();
  endtask

  task automatic push(input int r, input bit d, input int len);
    job_t j;
    j.dir = d;
    j.len = len;
    jq[r].push_back(j);
  endtask

  task automatic preset(input logic [7:0] v);
    preset_val = v;
    preset_req = 1'b1;
    tick();
    preset_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    bit pend;
    n = 0;
    do begin
      tick();
      n++;
      pend = 1'b0;
      for (int i = 0; i < N; i++) if (jq[i].size() > 0) pend = 1'b1;
    end while ((pend || busy) && n < budget);
    chk("idle_timeout", {pend, busy}, 0);
  endtask

  int exp_order[5];
  int base, ds, acc0;

  initial begin
    req_valid = '0;
    req_dir   = '0;
    req_len   = '0;
    for (int i = 0; i < N; i++) taken[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // single up job from 0x00
    push(0, 1'b1, 3); apply();
    wait_idle(100);
    chk("s1_count", last_count, 8'h03);
    chk("s1_ovf", last_ovf, 0);

    // wrap-around up
    preset(8'hFD);
    push(1, 1'b1, 4); apply();
    wait_idle(100);
    chk("wrap_up_count", last_count, 8'h01);
    chk("wrap_up_ovf", last_ovf, 1);

    // down with wrap
    preset(8'h02);
    push(2, 1'b0, 3); apply();
    wait_idle(100);
    chk("wrap_dn_count", last_count, 8'hFF);
    chk("wrap_dn_ovf", last_ovf, 1);

    // zero-length job
    preset(8'h55);
    push(3, 1'b1, 0); apply();
    wait_idle(100);
    chk("len0_count", last_count, 8'h55);
    chk("len0_ovf", last_ovf, 0);

    // round-robin fairness
    base = grant_log.size();
    push(0, 1'b1, 1); push(1, 1'b0, 1); push(2, 1'b1, 1); push(3, 1'b0, 1); push(0, 1'b1, 1);
    apply();
    wait_idle(200);
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;
    chk("rr_grants", grant_log.size() - base, 5);
    if (grant_log.size() >= base + 5) begin
      for (int k = 0; k < 5; k++) chk("rr_order", grant_log[base + k], exp_order[k]);
      for (int k = 0; k < 4; k++)
        chk("rr_gap", grant_cyc_log[base + k + 1] - grant_cyc_log[base + k], 4);
    end

    // full-length job
    preset(8'h10);
    push(0, 1'b1, 255); apply();
    wait_idle(400);
    chk("full_len_count", last_count, 8'h0F);
    chk("full_len_ovf", last_ovf, 1);

    // randomized bursts
    for (int b = 0; b < 8; b++) begin
      preset(8'($urandom_range(0, 255)));
      for (int i = 0; i < N; i++) begin
        int nj;
        nj = $urandom_range(0, 2);
        for (int k = 0; k < nj; k++)
          push(i, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 9));
      end
      apply();
      wait_idle(3000);
    end

    // reset in the 2nd RUN cycle of a len=10 job on requester 1
    acc0 = accept_cnt[1];
    push(1, 1'b1, 10); apply();
    for (int k = 0; k < 50 && accept_cnt[1] == acc0; k++) tick();
    chk("midrst_accepted", accept_cnt[1], acc0 + 1);
    tick();
    ds = done_seen[1];
    rst_n = 1'b0;
    #1;
    chk_zero("midrst_async");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_no_done", done_seen[1], ds);
    base = grant_log.size();
    push(2, 1'b0, 2); push(0, 1'b1, 2); apply();
    wait_idle(100);
    chk("post_rst_grants", grant_log.size() - base, 2);
    if (grant_log.size() >= base + 2) begin
      chk("post_rst_first", grant_log[base], 0);
      chk("post_rst_second", grant_log[base + 1], 2);
    end

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
